// File: rtl/reg_file_rv32i.sv
// RV32I integer register file: one write port, two registered read ports with write bypass, comb debug port.
// Operand reads land one cycle after reg_r_op; no stalls, every request is accepted.
module reg_file_rv32i #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reg_w_op,
  input  logic [4:0]      reg_w_reg_idx,
  input  logic [XLEN-1:0] reg_w_reg_val,
  input  logic            reg_r_op,
  input  logic [4:0]      reg_rs1,
  input  logic [4:0]      reg_rs2,
  output logic [XLEN-1:0] reg_rs1_val,
  output logic [XLEN-1:0] reg_rs2_val,
  output logic            reg_r_valid,
  input  logic [4:0]      dbg_idx,
  output logic [XLEN-1:0] dbg_val
);

  logic [XLEN-1:0] r_regs [REG_COUNT];
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic            r_r_valid;
  logic [XLEN-1:0] w_rs1_nxt;
  logic [XLEN-1:0] w_rs2_nxt;
  logic [XLEN-1:0] w_dbg_val;
  logic            w_wr_en;

  // Writes to x0 or beyond the implemented register count are dropped.
  assign w_wr_en = reg_w_op && (reg_w_reg_idx != 5'd0) && (int'(reg_w_reg_idx) < REG_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[reg_w_reg_idx] <= reg_w_reg_val;
    end
  end

  // Operand source select: x0 first, then same-cycle write bypass, then storage.
  always_comb begin
    w_rs1_nxt = '0;
    if (reg_rs1 != 5'd0) begin
      if (reg_w_op && (reg_w_reg_idx == reg_rs1)) begin
        w_rs1_nxt = reg_w_reg_val;
      end else if (int'(reg_rs1) < REG_COUNT) begin
        w_rs1_nxt = r_regs[reg_rs1];
      end
    end
  end

  always_comb begin
    w_rs2_nxt = '0;
    if (reg_rs2 != 5'd0) begin
      if (reg_w_op && (reg_w_reg_idx == reg_rs2)) begin
        w_rs2_nxt = reg_w_reg_val;
      end else if (int'(reg_rs2) < REG_COUNT) begin
        w_rs2_nxt = r_regs[reg_rs2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_r_valid <= 1'b0;
    end else begin
      r_r_valid <= reg_r_op;
      if (reg_r_op) begin
        r_rs1_val <= w_rs1_nxt;
        r_rs2_val <= w_rs2_nxt;
      end
    end
  end

  // Debug view shows committed state only; no bypass.
  always_comb begin
    w_dbg_val = '0;
    if ((dbg_idx != 5'd0) && (int'(dbg_idx) < REG_COUNT)) begin
      w_dbg_val = r_regs[dbg_idx];
    end
  end

  assign reg_rs1_val = r_rs1_val;
  assign reg_rs2_val = r_rs2_val;
  assign reg_r_valid = r_r_valid;
  assign dbg_val     = w_dbg_val;

endmodule

// File: tb/tb_reg_file_rv32i.sv
// Directed bench for reg_file_rv32i: reset, write/read, x0, bypass, hold, back-to-back, async reset.
module tb_reg_file_rv32i;

  logic        clk;
  logic        rst_n;
  logic        reg_w_op;
  logic [4:0]  reg_w_reg_idx;
  logic [31:0] reg_w_reg_val;
  logic        reg_r_op;
  logic [4:0]  reg_rs1;
  logic [4:0]  reg_rs2;
  logic [31:0] reg_rs1_val;
  logic [31:0] reg_rs2_val;
  logic        reg_r_valid;
  logic [4:0]  dbg_idx;
  logic [31:0] dbg_val;

  int n_cmp;
  int n_err;

  reg_file_rv32i #(.XLEN(32), .REG_COUNT(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_w_op     (reg_w_op),
    .reg_w_reg_idx(reg_w_reg_idx),
    .reg_w_reg_val(reg_w_reg_val),
    .reg_r_op     (reg_r_op),
    .reg_rs1      (reg_rs1),
    .reg_rs2      (reg_rs2),
    .reg_rs1_val  (reg_rs1_val),
    .reg_rs2_val  (reg_rs2_val),
    .reg_r_valid  (reg_r_valid),
    .dbg_idx      (dbg_idx),
    .dbg_val      (dbg_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wop, input logic [4:0] widx, input logic [31:0] wval,
                       input logic rop, input logic [4:0] rs1, input logic [4:0] rs2);
    reg_w_op      = wop;
    reg_w_reg_idx = widx;
    reg_w_reg_val = wval;
    reg_r_op      = rop;
    reg_rs1       = rs1;
    reg_rs2       = rs2;
  endtask

  initial begin
    logic [4:0]  b2b_idx [4];
    logic [31:0] b2b_exp [4];
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    dbg_idx = 5'd5;
    drive(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd4, 5'd4);
    tick();
    tick();
    chk("rst_rs1", reg_rs1_val, 32'h0);
    chk("rst_rs2", reg_rs2_val, 32'h0);
    chk("rst_valid", {31'b0, reg_r_valid}, 32'h0);
    dbg_idx = 5'd4;
    #1;
    chk("rst_dbg4", dbg_val, 32'h0);

    // Release reset, then read x5/x31
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    rst_n = 1'b1;
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd31);
    tick();
    chk("rd0_rs1", reg_rs1_val, 32'h0);
    chk("rd0_rs2", reg_rs2_val, 32'h0);
    chk("rd0_valid", {31'b0, reg_r_valid}, 32'h1);

    // Write x3 then read it
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
    tick();
    chk("wr_valid_low", {31'b0, reg_r_valid}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    tick();
    chk("x3_rs1", reg_rs1_val, 32'hDEAD_BEEF);
    chk("x3_rs2", reg_rs2_val, 32'h0);
    dbg_idx = 5'd3;
    #1;
    chk("x3_dbg", dbg_val, 32'hDEAD_BEEF);

    // x0 is immutable
    drive(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    dbg_idx = 5'd0;
    tick();
    chk("x0_rs1", reg_rs1_val, 32'h0);
    chk("x0_rs2", reg_rs2_val, 32'h0);
    chk("x0_dbg", dbg_val, 32'h0);

    // Bypass: write x7 and read x7 on both ports in the same cycle
    dbg_idx = 5'd7;
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 5'd7);
    #1;
    chk("byp_dbg_old", dbg_val, 32'h0);
    tick();
    chk("byp_rs1", reg_rs1_val, 32'hA5A5_A5A5);
    chk("byp_rs2", reg_rs2_val, 32'hA5A5_A5A5);
    chk("byp_dbg_new", dbg_val, 32'hA5A5_A5A5);

    // Hold while idle
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7);
    tick();
    chk("hold_rd_valid", {31'b0, reg_r_valid}, 32'h1);
    drive(1'b1, 5'd3, 32'h5555_5555, 1'b0, 5'd9, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_valid", {31'b0, reg_r_valid}, 32'h0);
      chk("idle_rs1", reg_rs1_val, 32'hDEAD_BEEF);
      chk("idle_rs2", reg_rs2_val, 32'hA5A5_A5A5);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
    end

    // Back-to-back writes to x9 with reads between and alongside
    drive(1'b1, 5'd9, 32'h0000_0111, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3);
    tick();
    chk("b2b_first", reg_rs1_val, 32'h0000_0111);
    chk("b2b_x3new", reg_rs2_val, 32'h5555_5555);
    drive(1'b1, 5'd9, 32'h0000_0222, 1'b1, 5'd9, 5'd9);
    tick();
    chk("b2b_byp_rs1", reg_rs1_val, 32'h0000_0222);
    chk("b2b_byp_rs2", reg_rs2_val, 32'h0000_0222);

    // Four consecutive reads
    b2b_idx[0] = 5'd3; b2b_exp[0] = 32'h5555_5555;
    b2b_idx[1] = 5'd7; b2b_exp[1] = 32'hA5A5_A5A5;
    b2b_idx[2] = 5'd9; b2b_exp[2] = 32'h0000_0222;
    b2b_idx[3] = 5'd0; b2b_exp[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, b2b_idx[i], 5'd7);
      tick();
      chk("seq_valid", {31'b0, reg_r_valid}, 32'h1);
      chk("seq_rs1", reg_rs1_val, b2b_exp[i]);
    end

    // Fill x1..x31 with index*0x01010101
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 1'b0, 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd31);
    tick();
    chk("fill_x1", reg_rs1_val, 32'h0101_0101);
    chk("fill_x31", reg_rs2_val, 32'h1F1F_1F1F);
    dbg_idx = 5'd16;
    #1;
    chk("fill_dbg16", dbg_val, 32'h1010_1010);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rs1", reg_rs1_val, 32'h0);
    chk("arst_rs2", reg_rs2_val, 32'h0);
    chk("arst_valid", {31'b0, reg_r_valid}, 32'h0);
    chk("arst_dbg16", dbg_val, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    rst_n = 1'b1;
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd31);
    tick();
    chk("post_x1", reg_rs1_val, 32'h0);
    chk("post_x31", reg_rs2_val, 32'h0);
    chk("post_valid", {31'b0, reg_r_valid}, 32'h1);
    dbg_idx = 5'd31;
    #1;
    chk("post_dbg31", dbg_val, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
